// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame receiver.
//   - rx_state_e : receiver FSM states
//   - DATA_W_DEFAULT / BAUD_DIV_DEFAULT : default frame geometry
//   - FRAME_BITS / frame_bits() : serial bits per frame (start + data + parity + stop)
package parity_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_e;

  localparam int DATA_W_DEFAULT   = 8;
  localparam int BAUD_DIV_DEFAULT = 4;
  localparam int FRAME_BITS       = DATA_W_DEFAULT + 3;

  function automatic int frame_bits(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Loadable baud down-counter producing the mid-bit sample tick.
//   clk       : system clock
//   rst       : synchronous active-high reset (counter -> 0)
//   en        : count enable; while high the counter decrements / reloads
//   load_half : load BAUD_DIV/2-1 so the first tick lands mid start bit
//   tick      : high in the cycle the counter is 0 while enabled
module baud_tick_gen
  import parity_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load_half,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_half)   cnt_d = HALF_M1;
    else if (en)     cnt_d = (cnt_q == '0) ? FULL_M1 : cnt_q - CW'(1);
  end

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit,
// stop bit. Presents the frame in parallel for the downstream parity checker.
//   clk, rst    : clock, synchronous active-high reset
//   rx          : serial line, idle high, asynchronous to clk
//   data        : last good frame's data (bit 0 = first received)
//   parity_bit  : last good frame's parity bit
//   frame_valid : one-cycle pulse when data/parity_bit update
//   framing_err : one-cycle pulse when the stop bit samples low
//   busy        : FSM not in IDLE
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              parity_bit,
  output logic              frame_valid,
  output logic              framing_err,
  output logic              busy
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  // Two-flop synchroniser; resets to the idle-high line level.
  logic rx_s1_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s_q  <= rx_s1_q;
    end
  end

  rx_state_e         state_q, state_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              parity_q, parity_d;
  logic              fv_q, fv_d;
  logic              fe_q, fe_d;

  logic cnt_en, load_half, tick;

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .load_half (load_half),
    .tick      (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    parity_d  = parity_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    cnt_en    = 1'b0;
    load_half = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Half-period load puts every later tick at mid-bit.
        if (!rx_s_q) begin
          load_half = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        cnt_en = 1'b1;
        if (tick) begin
          if (rx_s_q) state_d = S_IDLE;  // false start: line back high
          else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        cnt_en = 1'b1;
        if (tick) begin
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == LAST_IDX) state_d = S_PARITY;
          else                       bit_idx_d = bit_idx_q + IW'(1);
        end
      end
      S_PARITY: begin
        cnt_en = 1'b1;
        if (tick) begin
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_en = 1'b1;
        if (tick) begin
          if (rx_s_q) begin
            data_d   = shift_q;
            parity_d = par_q;
            fv_d     = 1'b1;
            state_d  = S_IDLE;  // mid-stop: ready for a back-to-back start
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line must not be mistaken for a stream of start bits.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  assign data        = data_q;
  assign parity_bit  = parity_q;
  assign frame_valid = fv_q;
  assign framing_err = fe_q;
  assign busy        = (state_q != S_IDLE);

endmodule
